// File: rtl/mem_arb_pkg.sv
// ============================================================================
// mem_arb_pkg : FSM state and owner encodings shared by the MEM arbiter files
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

endpackage

`default_nettype wire

// File: rtl/mem_arb_grant.sv
// ============================================================================
// mem_arb_grant : combinational IFU/LSU grant; MEM_ARB_RR_EN selects round-robin
// Revision      : 1.0
// ============================================================================
`default_nettype none

module mem_arb_grant
    import mem_arb_pkg::*;
(
    input  logic   ifu_req_valid,
    input  logic   lsu_req_valid,
    input  owner_t last_owner,
    output logic   gnt_ifu,
    output logic   gnt_lsu
);

`ifdef MEM_ARB_RR_EN
    // On a tie the master that was not served last wins.
    always_comb begin
        gnt_lsu = lsu_req_valid && (!ifu_req_valid || (last_owner == OWN_IFU));
        gnt_ifu = ifu_req_valid && !gnt_lsu;
    end
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    always_comb begin
        gnt_lsu = lsu_req_valid;
        gnt_ifu = ifu_req_valid && !lsu_req_valid;
    end
`endif

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : serialises IFU/LSU transactions onto one MEM port with LATENCY
//               cycles of delay; define MEM_ARB_RR_EN for round-robin grant
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int LATENCY = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ifu_req_valid,
    output logic            ifu_req_ready,
    input  logic [AW-1:0]   ifu_addr,
    output logic            ifu_resp_valid,
    input  logic            ifu_resp_ready,
    output logic [DW-1:0]   ifu_rdata,
    input  logic            lsu_req_valid,
    output logic            lsu_req_ready,
    input  logic            lsu_wen,
    input  logic [AW-1:0]   lsu_addr,
    input  logic [DW-1:0]   lsu_wdata,
    input  logic [DW/8-1:0] lsu_mask,
    output logic            lsu_resp_valid,
    input  logic            lsu_resp_ready,
    output logic [DW-1:0]   lsu_rdata,
    output logic            mem_ren,
    output logic            mem_wen,
    output logic [AW-1:0]   mem_raddr,
    output logic [AW-1:0]   mem_waddr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_mask,
    input  logic [DW-1:0]   mem_rdata
);

    localparam int            MW       = DW / 8;
    localparam int            CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    state_t          state_q, state_d;
    owner_t          owner_q, owner_d;
    logic            wen_q, wen_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [MW-1:0]   mask_q, mask_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   ifu_rdata_q, ifu_rdata_d;
    logic [DW-1:0]   lsu_rdata_q, lsu_rdata_d;
    logic            gnt_ifu, gnt_lsu;
    logic            accept, strobe, resp_done;
    owner_t          last_owner;

    mem_arb_grant u_grant (
        .ifu_req_valid (ifu_req_valid),
        .lsu_req_valid (lsu_req_valid),
        .last_owner    (last_owner),
        .gnt_ifu       (gnt_ifu),
        .gnt_lsu       (gnt_lsu)
    );

    // Ready is gated by reset so nothing is offered while rst is held low.
    assign ifu_req_ready = rst && (state_q == ST_IDLE) && gnt_ifu;
    assign lsu_req_ready = rst && (state_q == ST_IDLE) && gnt_lsu;
    assign accept        = ifu_req_ready || lsu_req_ready;
    assign strobe        = (state_q == ST_BUSY) && (cnt_q == '0);
    assign resp_done     = (owner_q == OWN_LSU) ? lsu_resp_ready : ifu_resp_ready;

`ifdef MEM_ARB_RR_EN
    owner_t last_owner_q, last_owner_d;

    always_comb begin
        last_owner_d = last_owner_q;
        if (accept) begin
            last_owner_d = lsu_req_ready ? OWN_LSU : OWN_IFU;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_owner_q <= OWN_IFU;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end

    assign last_owner = last_owner_q;
`else
    assign last_owner = OWN_IFU;
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        wen_d       = wen_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mask_d      = mask_q;
        cnt_d       = cnt_q;
        ifu_rdata_d = ifu_rdata_q;
        lsu_rdata_d = lsu_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    owner_d = lsu_req_ready ? OWN_LSU : OWN_IFU;
                    wen_d   = lsu_req_ready && lsu_wen;
                    addr_d  = lsu_req_ready ? lsu_addr : ifu_addr;
                    wdata_d = lsu_req_ready ? lsu_wdata : '0;
                    mask_d  = lsu_req_ready ? lsu_mask : '0;
                    cnt_d   = CNT_INIT;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (strobe) begin
                    state_d = ST_RESP;
                    if (owner_q == OWN_LSU) begin
                        lsu_rdata_d = wen_q ? '0 : mem_rdata;
                    end else begin
                        ifu_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_RESP: begin
                if (resp_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IFU;
            wen_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mask_q      <= '0;
            cnt_q       <= '0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            wen_q       <= wen_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mask_q      <= mask_d;
            cnt_q       <= cnt_d;
            ifu_rdata_q <= ifu_rdata_d;
            lsu_rdata_q <= lsu_rdata_d;
        end
    end

    assign mem_ren        = strobe && !wen_q;
    assign mem_wen        = strobe && wen_q;
    assign mem_raddr      = addr_q;
    assign mem_waddr      = addr_q;
    assign mem_wdata      = wdata_q;
    assign mem_mask       = mask_q;
    assign ifu_resp_valid = (state_q == ST_RESP) && (owner_q == OWN_IFU);
    assign lsu_resp_valid = (state_q == ST_RESP) && (owner_q == OWN_LSU);
    assign ifu_rdata      = ifu_rdata_q;
    assign lsu_rdata      = lsu_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter : scoreboard bench for mem_arbiter at LATENCY=1 and LATENCY=3
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    typedef struct {
        bit          lsu;
        bit          wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] rdata;
    } txn_t;

    logic        clk;
    logic [1:0]  rst;
    logic [1:0]  ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
    logic [1:0]  lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready;
    logic [1:0]  mem_ren, mem_wen;
    logic [31:0] ifu_addr  [2];
    logic [31:0] ifu_rdata [2];
    logic [31:0] lsu_addr  [2];
    logic [31:0] lsu_wdata [2];
    logic [3:0]  lsu_mask  [2];
    logic [31:0] lsu_rdata [2];
    logic [31:0] mem_raddr [2];
    logic [31:0] mem_waddr [2];
    logic [31:0] mem_wdata [2];
    logic [3:0]  mem_mask  [2];
    logic [31:0] mem_rdata [2];

    int   checks = 0;
    int   passes = 0;
    int   cyc    = 0;
    txn_t exp_q [$];
    txn_t rsp_q [$];
    txn_t e;
    bit   hs;
    int   acc_cyc [2];
    bit   acc_lsu [2];
    bit   pend    [2];
    bit   rv_seen [2];

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h8000_0000: rom = 32'h0010_0093;
            32'h8000_0004: rom = 32'h0020_0113;
            32'h8000_0008: rom = 32'h0030_0193;
            32'h8000_0200: rom = 32'hCAFE_F00D;
            default:       rom = 32'h0;
        endcase
    endfunction

    function automatic int lat(input int k);
        lat = (k == 0) ? 1 : 3;
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g_dut
        mem_arbiter #(.AW(32), .DW(32), .LATENCY((k == 0) ? 1 : 3)) u_dut (
            .clk            (clk),
            .rst            (rst[k]),
            .ifu_req_valid  (ifu_req_valid[k]),
            .ifu_req_ready  (ifu_req_ready[k]),
            .ifu_addr       (ifu_addr[k]),
            .ifu_resp_valid (ifu_resp_valid[k]),
            .ifu_resp_ready (ifu_resp_ready[k]),
            .ifu_rdata      (ifu_rdata[k]),
            .lsu_req_valid  (lsu_req_valid[k]),
            .lsu_req_ready  (lsu_req_ready[k]),
            .lsu_wen        (lsu_wen[k]),
            .lsu_addr       (lsu_addr[k]),
            .lsu_wdata      (lsu_wdata[k]),
            .lsu_mask       (lsu_mask[k]),
            .lsu_resp_valid (lsu_resp_valid[k]),
            .lsu_resp_ready (lsu_resp_ready[k]),
            .lsu_rdata      (lsu_rdata[k]),
            .mem_ren        (mem_ren[k]),
            .mem_wen        (mem_wen[k]),
            .mem_raddr      (mem_raddr[k]),
            .mem_waddr      (mem_waddr[k]),
            .mem_wdata      (mem_wdata[k]),
            .mem_mask       (mem_mask[k]),
            .mem_rdata      (mem_rdata[k])
        );
        assign mem_rdata[k] = rom(mem_raddr[k]);
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) begin
            passes++;
        end else begin
            $display("FAIL %s dut%0d: actual=%0h required=%0h", name, k, act, req);
        end
    endtask

    // Monitor: all output checking happens here, away from the active edge.
    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (!rst[k]) begin
                pend[k]    = 1'b0;
                rv_seen[k] = 1'b0;
                chk("reset_flags", k, {ifu_req_ready[k], lsu_req_ready[k], ifu_resp_valid[k],
                                       lsu_resp_valid[k], mem_ren[k], mem_wen[k]}, 64'h0);
                chk("reset_regs", k, ifu_rdata[k] | lsu_rdata[k] | mem_raddr[k] | mem_waddr[k] |
                                     mem_wdata[k] | {28'h0, mem_mask[k]}, 64'h0);
            end else begin
                if (ifu_req_ready[k] || lsu_req_ready[k]) begin
                    chk("ready_onehot", k, ifu_req_ready[k] & lsu_req_ready[k], 64'h0);
                    chk("ready_needs_valid", k, (ifu_req_ready[k] & ~ifu_req_valid[k]) |
                                                (lsu_req_ready[k] & ~lsu_req_valid[k]), 64'h0);
                    acc_cyc[k] = cyc;
                    acc_lsu[k] = lsu_req_ready[k];
                    pend[k]    = 1'b1;
                end
                if (mem_ren[k] || mem_wen[k]) begin
                    chk("strobe_onehot", k, mem_ren[k] & mem_wen[k], 64'h0);
                    chk("strobe_pending", k, pend[k], 64'h1);
                    chk("strobe_latency", k, cyc - acc_cyc[k], lat(k));
                    pend[k] = 1'b0;
                    chk("strobe_expected", k, exp_q.size() != 0, 64'h1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("grant_owner", k, acc_lsu[k], e.lsu);
                        chk("strobe_kind", k, mem_wen[k], e.wen);
                        chk("mem_addr", k, e.wen ? mem_waddr[k] : mem_raddr[k], e.addr);
                        if (e.wen) begin
                            chk("mem_wdata", k, mem_wdata[k], e.wdata);
                            chk("mem_mask", k, mem_mask[k], e.mask);
                        end
                        rsp_q.push_back(e);
                    end
                end
                if (ifu_resp_valid[k] || lsu_resp_valid[k]) begin
                    chk("resp_onehot", k, ifu_resp_valid[k] & lsu_resp_valid[k], 64'h0);
                    chk("resp_no_accept", k, ifu_req_ready[k] | lsu_req_ready[k], 64'h0);
                    if (!rv_seen[k]) begin
                        chk("resp_latency", k, cyc - acc_cyc[k], lat(k) + 1);
                    end
                    rv_seen[k] = 1'b1;
                    chk("resp_expected", k, rsp_q.size() != 0, 64'h1);
                    if (rsp_q.size() != 0) begin
                        e = rsp_q[0];
                        chk("resp_owner", k, lsu_resp_valid[k], e.lsu);
                        chk("resp_rdata", k, lsu_resp_valid[k] ? lsu_rdata[k] : ifu_rdata[k], e.rdata);
                        hs = lsu_resp_valid[k] ? lsu_resp_ready[k] : ifu_resp_ready[k];
                        if (hs) begin
                            void'(rsp_q.pop_front());
                            rv_seen[k] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    task automatic expect_txn(input bit lsu, input bit wen, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] mask,
                              input logic [31:0] rdata);
        txn_t t;
        t.lsu = lsu; t.wen = wen; t.addr = addr; t.wdata = wdata; t.mask = mask; t.rdata = rdata;
        exp_q.push_back(t);
    endtask

    // Raise a request at posedge+1 and hold it until the handshake edge.
    task automatic req(input int k, input bit lsu, input bit wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] mask);
        bit got = 1'b0;
        if (lsu) begin
            lsu_req_valid[k] = 1'b1; lsu_wen[k] = wen; lsu_addr[k] = addr;
            lsu_wdata[k] = wdata; lsu_mask[k] = mask;
        end else begin
            ifu_req_valid[k] = 1'b1; ifu_addr[k] = addr;
        end
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (lsu ? lsu_req_ready[k] : ifu_req_ready[k]) begin
                got = 1'b1;
                break;
            end
        end
        chk("req_handshake", k, got, 64'h1);
        @(posedge clk);
        #1;
        if (lsu) lsu_req_valid[k] = 1'b0;
        else     ifu_req_valid[k] = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || rsp_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 0, exp_q.size() + rsp_q.size(), 64'h0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 2'b11;
        ifu_req_valid = '0; lsu_req_valid = '0; lsu_wen = '0;
        ifu_resp_ready = 2'b11; lsu_resp_ready = 2'b11;
        for (int k = 0; k < 2; k++) begin
            ifu_addr[k] = '0; lsu_addr[k] = '0; lsu_wdata[k] = '0; lsu_mask[k] = '0;
        end
        #2 rst = 2'b00;
        repeat (3) @(posedge clk);
        #1 rst = 2'b11;

        // LATENCY=1 instance: IFU read, LSU write, LSU read
        expect_txn(1'b0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'h0010_0093);
        req(0, 1'b0, 1'b0, 32'h8000_0000, 32'h0, 4'h0);
        wait_idle();
        expect_txn(1'b1, 1'b1, 32'h8000_0100, 32'hDEAD_BEEF, 4'b0011, 32'h0);
        req(0, 1'b1, 1'b1, 32'h8000_0100, 32'hDEAD_BEEF, 4'b0011);
        wait_idle();
        expect_txn(1'b1, 1'b0, 32'h8000_0200, 32'h0, 4'h0, 32'hCAFE_F00D);
        req(0, 1'b1, 1'b0, 32'h8000_0200, 32'h0, 4'h0);
        wait_idle();

        // Response backpressure: IFU holds resp_ready low while LSU waits
        ifu_resp_ready[0] = 1'b0;
        expect_txn(1'b0, 1'b0, 32'h8000_0008, 32'h0, 4'h0, 32'h0030_0193);
        expect_txn(1'b1, 1'b1, 32'h8000_0400, 32'h0000_00A5, 4'b0001, 32'h0);
        req(0, 1'b0, 1'b0, 32'h8000_0008, 32'h0, 4'h0);
        fork
            req(0, 1'b1, 1'b1, 32'h8000_0400, 32'h0000_00A5, 4'b0001);
            begin
                bit seen = 1'b0;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (ifu_resp_valid[0]) begin
                        seen = 1'b1;
                        break;
                    end
                end
                chk("bp_resp_seen", 0, seen, 64'h1);
                repeat (5) @(posedge clk);
                #1 ifu_resp_ready[0] = 1'b1;
            end
        join
        wait_idle();

        // LATENCY=3 instance: reset while an LSU write is in flight drops it
        req(1, 1'b1, 1'b1, 32'h8000_0500, 32'h1234_5678, 4'b1111);
        rst[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst[1] = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        // Simultaneous requests right after reset
`ifdef MEM_ARB_RR_EN
        expect_txn(1'b1, 1'b0, 32'h8000_0200, 32'h0, 4'h0, 32'hCAFE_F00D);
        expect_txn(1'b0, 1'b0, 32'h8000_0004, 32'h0, 4'h0, 32'h0020_0113);
        expect_txn(1'b1, 1'b1, 32'h8000_0300, 32'h1122_3344, 4'b1100, 32'h0);
        expect_txn(1'b0, 1'b0, 32'h8000_0008, 32'h0, 4'h0, 32'h0030_0193);
`else
        expect_txn(1'b1, 1'b0, 32'h8000_0200, 32'h0, 4'h0, 32'hCAFE_F00D);
        expect_txn(1'b1, 1'b1, 32'h8000_0300, 32'h1122_3344, 4'b1100, 32'h0);
        expect_txn(1'b0, 1'b0, 32'h8000_0004, 32'h0, 4'h0, 32'h0020_0113);
        expect_txn(1'b0, 1'b0, 32'h8000_0008, 32'h0, 4'h0, 32'h0030_0193);
`endif
        fork
            begin
                req(1, 1'b1, 1'b0, 32'h8000_0200, 32'h0, 4'h0);
                req(1, 1'b1, 1'b1, 32'h8000_0300, 32'h1122_3344, 4'b1100);
            end
            begin
                req(1, 1'b0, 1'b0, 32'h8000_0004, 32'h0, 4'h0);
                req(1, 1'b0, 1'b0, 32'h8000_0008, 32'h0, 4'h0);
            end
        join
        wait_idle();

        // Single IFU read at LATENCY=3
        expect_txn(1'b0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'h0010_0093);
        req(1, 1'b0, 1'b0, 32'h8000_0000, 32'h0, 4'h0);
        wait_idle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
